instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 24 ++
 rtl/instr_sequencer_if.sv | 28 ++
 rtl/instr_sequencer_seq_timeout_counter.sv | 32 +++
 rtl/instr_sequencer.sv | 116 +++++++++++
 tb/tb_instr_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared control-unit definitions for the instruction sequencer.
// Holds the FSM encoding, the decoder micro-step width and a counter-width helper.
// Imported by the interface, the sequencer top and its timeout counter.
package instr_sequencer_pkg;

  // Width of the micro-step counter that feeds the decoder state input.
  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] ustep_t;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_HALTED = 3'd3,
    SEQ_FAULT  = 3'd4
  } seq_state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: instruction-memory fetch, decoder feedback, control outputs.
// master = sequencer side, slave = memory/decoder/datapath side.
// No flow control beyond the imem_req/imem_valid strobe pair.
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  ustep_t      next_state;
  logic        halt;
  logic [31:0] I;
  ustep_t      state;
  logic        exec_en;
  logic        fault;
  logic        halted;

  modport master (
    output imem_req, I, state, exec_en, fault, halted,
    input  imem_rdata, imem_valid, next_state, halt
  );

  modport slave (
    input  imem_req, I, state, exec_en, fault, halted,
    output imem_rdata, imem_valid, next_state, halt
  );

endinterface

// File: rtl/instr_sequencer_seq_timeout_counter.sv
// Fetch timeout counter: counts enabled cycles, flags the last allowed cycle.
// Latency: o_expired is decoded from the count register, valid the same cycle.
// Saturates at LIMIT-1 rather than wrapping; clear has priority over enable.
module seq_timeout_counter
  import instr_sequencer_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = cnt_w(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Count enabled cycles, holding at LAST until cleared.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch into I, step the decoder micro-state, halt/fault.
// Latency: fetch response to first exec_en is one cycle; all outputs registered.
// Memory stalls are tolerated for FETCH_TIMEOUT cycles, after which FAULT sticks.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int MAX_STEPS     = 4
) (
  input  logic                clock,
  input  logic                reset,
  instr_sequencer_if.master   bus
);

  localparam int SW = cnt_w(MAX_STEPS);
  localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);

  seq_state_t  r_st;
  logic [31:0] r_I;
  ustep_t      r_state;
  logic [SW-1:0] r_step;
  logic        r_req;
  logic        r_exec;
  logic        r_fault;
  logic        r_halted;

  logic w_expired;
  logic w_in_fetch;
  logic w_done;

  assign w_in_fetch = (r_st == SEQ_FETCH);
  // An instruction ends on a zero next_state or when it has used its step budget.
  assign w_done     = (bus.next_state == '0) || (r_step == STEP_LAST);

  seq_timeout_counter #(.LIMIT(FETCH_TIMEOUT)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!w_in_fetch || bus.imem_valid),
    .i_enable  (w_in_fetch),
    .o_expired (w_expired)
  );

  // Sequencer FSM; outputs are set alongside the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_st     <= SEQ_IDLE;
      r_I      <= '0;
      r_state  <= '0;
      r_step   <= '0;
      r_req    <= 1'b0;
      r_exec   <= 1'b0;
      r_fault  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_st)
        SEQ_IDLE: begin
          r_st  <= SEQ_FETCH;
          r_req <= 1'b1;
        end
        SEQ_FETCH: begin
          // A response on the last allowed cycle still wins over the timeout.
          if (bus.imem_valid) begin
            r_I     <= bus.imem_rdata;
            r_state <= '0;
            r_step  <= '0;
            r_st    <= SEQ_EXEC;
            r_req   <= 1'b0;
            r_exec  <= 1'b1;
          end else if (w_expired) begin
            r_st    <= SEQ_FAULT;
            r_req   <= 1'b0;
            r_fault <= 1'b1;
          end
        end
        SEQ_EXEC: begin
          if (w_done) begin
            r_state <= '0;
            r_step  <= '0;
            r_exec  <= 1'b0;
            if (bus.halt) begin
              r_st     <= SEQ_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_st  <= SEQ_FETCH;
              r_req <= 1'b1;
            end
          end else begin
            r_state <= bus.next_state;
            r_step  <= r_step + 1'b1;
          end
        end
        SEQ_HALTED: begin
          if (!bus.halt) begin
            r_st     <= SEQ_FETCH;
            r_halted <= 1'b0;
            r_req    <= 1'b1;
          end
        end
        SEQ_FAULT: begin
          r_st <= SEQ_FAULT;
        end
        default: begin
          r_st <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req = r_req;
  assign bus.I        = r_I;
  assign bus.state    = r_state;
  assign bus.exec_en  = r_exec;
  assign bus.fault    = r_fault;
  assign bus.halted   = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: driver issues instructions and queues
// the expected exec-cycle (I, state) pairs; a negedge monitor pops and compares.
// Directed cases cover reset, multi-step, forced refetch, halt and timeout.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int FT = 16;
  localparam int MS = 4;

  typedef struct packed {
    logic [31:0] i;
    logic [1:0]  st;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [31:0] last_i = 32'h0;

  always #5 clock = ~clock;

  instr_sequencer_if bus();

  instr_sequencer #(.FETCH_TIMEOUT(FT), .MAX_STEPS(MS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every exec_en cycle must match the next queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (bus.exec_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("exec_unexpected", 32'(bus.exec_en), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("exec_I", bus.I, e.i);
        chk("exec_state", 32'(bus.state), 32'(e.st));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = $urandom;
    @(negedge clock);
    chk("rst_I", bus.I, 32'h0);
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_exec", 32'(bus.exec_en), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    sb.delete();
    last_i = 32'h0;
    reset = 1'b0;
    // Response during the IDLE cycle must be discarded.
    @(negedge clock);
    chk("idle_to_fetch_req", 32'(bus.imem_req), 32'h1);
    chk("idle_discard_I", bus.I, 32'h0);
    chk("idle_exec", 32'(bus.exec_en), 32'h0);
    bus.imem_valid = 1'b0;
  endtask

  task automatic wait_fetch(output bit ok);
    int cyc = 0;
    while (bus.imem_req !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    ok = (bus.imem_req === 1'b1);
    if (!ok) chk("fetch_wait", 32'(bus.imem_req), 32'h1);
  endtask

  // One instruction: nsteps exec cycles requested (last next_state=0), capped at MS.
  task automatic do_instr(input logic [31:0] w, input int lat, input int nsteps,
                          input int fixed_ns, input bit hlt, input int abort_at);
    logic [1:0] ns[$];
    logic [1:0] s;
    int ncyc;
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    for (int j = 0; j < nsteps && j < MS; j++) begin
      if (j == nsteps - 1) ns.push_back(2'd0);
      else if (fixed_ns != 0) ns.push_back(2'(fixed_ns));
      else ns.push_back(2'($urandom_range(1, 3)));
    end
    ncyc = ns.size();
    s = 2'd0;
    for (int j = 0; j < ncyc; j++) begin
      sb.push_back({w, s});
      s = ns[j];
    end
    for (int k = 0; k < lat; k++) begin
      bus.imem_rdata = $urandom;
      bus.halt = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = w;
    @(negedge clock);
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    for (int j = 0; j < ncyc; j++) begin
      if (j == abort_at) begin
        do_reset();
        return;
      end
      bus.next_state = ns[j];
      bus.halt = (j == ncyc - 1) ? hlt : 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    bus.next_state = 2'($urandom_range(0, 3));
    last_i = w;
    chk("done_state", 32'(bus.state), 32'h0);
    chk("done_exec", 32'(bus.exec_en), 32'h0);
    chk("hold_I", bus.I, w);
    if (hlt) begin
      chk("halted_set", 32'(bus.halted), 32'h1);
      chk("halted_req", 32'(bus.imem_req), 32'h0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      chk("halted_hold", 32'(bus.halted), 32'h1);
      bus.halt = 1'b0;
      @(negedge clock);
      chk("unhalt_req", 32'(bus.imem_req), 32'h1);
      chk("unhalt_halted", 32'(bus.halted), 32'h0);
    end else begin
      chk("refetch_req", 32'(bus.imem_req), 32'h1);
    end
  endtask

  // Memory never answers: fault appears after FT cycles of FETCH and sticks.
  task automatic do_timeout();
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    for (int k = 0; k < FT; k++) begin
      if (k == FT - 1) begin
        chk("to_last_fault", 32'(bus.fault), 32'h0);
        chk("to_last_req", 32'(bus.imem_req), 32'h1);
      end
      bus.halt = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    chk("to_fault", 32'(bus.fault), 32'h1);
    chk("to_req", 32'(bus.imem_req), 32'h0);
    chk("to_exec", 32'(bus.exec_en), 32'h0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = $urandom;
    bus.halt = 1'b0;
    repeat (5) @(negedge clock);
    chk("to_sticky", 32'(bus.fault), 32'h1);
    chk("to_hold_I", bus.I, last_i);
    chk("to_sticky_req", 32'(bus.imem_req), 32'h0);
    bus.imem_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.next_state = 2'd0;
    bus.halt = 1'b0;
    do_reset();
    do_instr(32'hF2800041, 3, 1, 0, 1'b0, -1);
    do_instr($urandom, 2, 2, 1, 1'b0, -1);
    do_instr($urandom, 0, 100, 3, 1'b0, -1);
    do_instr($urandom, FT - 1, 2, 0, 1'b1, -1);
    do_instr($urandom, 1, 3, 2, 1'b0, 1);
    for (int n = 0; n < 40; n++) begin
      lat = ($urandom_range(0, 3) == 0) ? FT - 1 : int'($urandom_range(0, 6));
      do_instr($urandom, lat, int'($urandom_range(1, 6)), 0,
               ($urandom_range(0, 3) == 0), -1);
    end
    do_timeout();
    do_reset();
    do_instr($urandom, 2, 3, 0, 1'b0, -1);
    @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
